// File: rtl/scan_retime_bank_pkg.sv
// Shared types and legal parameter ranges for the scan-out retiming bank.
package scan_retime_bank_pkg;

  localparam int unsigned NUM_CHAINS_MIN = 1;
  localparam int unsigned NUM_CHAINS_MAX = 16;
  localparam int unsigned SKEW_DEPTH_MIN = 1;
  localparam int unsigned SKEW_DEPTH_MAX = 4;
  localparam int unsigned CNT_W_MIN      = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_e;

  typedef enum logic {
    MODE_PARALLEL = 1'b0,
    MODE_COMPACT  = 1'b1
  } scan_mode_e;

endpackage

// File: rtl/scan_retime_stage.sv
// Single-channel retiming pipe: SKEW_DEPTH flops that advance only when adv is high.
module scan_retime_stage
  import scan_retime_bank_pkg::*;
#(
  parameter int unsigned SKEW_DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic d,
  output logic q
);

  if (SKEW_DEPTH < SKEW_DEPTH_MIN || SKEW_DEPTH > SKEW_DEPTH_MAX) begin : g_bad_depth
    $error("scan_retime_stage: SKEW_DEPTH out of range");
  end

  logic [SKEW_DEPTH-1:0] pipe;

  if (SKEW_DEPTH == 1) begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      pipe <= '0;
      else if (adv) pipe <= d;
    end
  end else begin : g_multi
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      pipe <= '0;
      else if (adv) pipe <= {pipe[SKEW_DEPTH-2:0], d};
    end
  end

  assign q = pipe[SKEW_DEPTH-1];

endmodule

// File: rtl/scan_retime_bank.sv
// Scan-out retiming bank: per-channel skew pipes, optional XOR compaction,
// and a pattern FSM that counts shifts and flags patterns cut short.
module scan_retime_bank
  import scan_retime_bank_pkg::*;
#(
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned SKEW_DEPTH = 1,
  parameter int unsigned CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  se,
  input  logic                  hold_outputs,
  input  logic                  compact_mode,
  input  logic [CNT_W-1:0]      shift_len,
  input  logic                  err_clr,
  input  logic [NUM_CHAINS-1:0] chain_in,
  output logic [NUM_CHAINS-1:0] so,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic                  shift_done,
  output logic                  short_err
);

  if (NUM_CHAINS < NUM_CHAINS_MIN || NUM_CHAINS > NUM_CHAINS_MAX) begin : g_bad_chains
    $error("scan_retime_bank: NUM_CHAINS out of range");
  end
  if (SKEW_DEPTH < SKEW_DEPTH_MIN || SKEW_DEPTH > SKEW_DEPTH_MAX) begin : g_bad_depth
    $error("scan_retime_bank: SKEW_DEPTH out of range");
  end
  if (CNT_W < CNT_W_MIN) begin : g_bad_cnt
    $error("scan_retime_bank: CNT_W out of range");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                  adv;
  logic [NUM_CHAINS-1:0] last;

  scan_state_e      state_q, state_d;
  scan_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             err_set;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;

  assign adv = se & ~hold_outputs;

  for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
    scan_retime_stage #(
      .SKEW_DEPTH(SKEW_DEPTH)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .d   (chain_in[i]),
      .q   (last[i])
    );
  end

  // so decodes registered stage/mode state directly so the lag stays exactly SKEW_DEPTH.
  always_comb begin
    so = last;
    if (mode_q == MODE_COMPACT) so = NUM_CHAINS'(^last);
  end

  assign len_eff = (shift_len == '0) ? CNT_ONE : shift_len;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PARALLEL;
      len_q   <= CNT_ONE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Pattern FSM: start counts as shift 1; abort from SHIFT on se low, even while held.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mode_d = scan_mode_e'(compact_mode);
        cnt_d  = '0;
        if (adv) begin
          len_d = len_eff;
          cnt_d = CNT_ONE;
          if (len_eff == CNT_ONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (!se) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else if (!hold_outputs) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!se) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr);
  end

  assign shift_cnt  = cnt_q;
  assign shift_done = done_q;
  assign short_err  = err_q;

endmodule

// File: tb/tb_scan_retime_bank.sv
// Directed bench for scan_retime_bank (4 chains, 2-deep skew): vector table plus hold/reset sequences.
module tb_scan_retime_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        se;
  logic        hold_outputs;
  logic        compact_mode;
  logic [11:0] shift_len;
  logic        err_clr;
  logic [3:0]  chain_in;
  logic [3:0]  so;
  logic [11:0] shift_cnt;
  logic        shift_done;
  logic        short_err;

  int checks   = 0;
  int failures = 0;

  scan_retime_bank #(
    .NUM_CHAINS(4),
    .SKEW_DEPTH(2),
    .CNT_W     (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .se          (se),
    .hold_outputs(hold_outputs),
    .compact_mode(compact_mode),
    .shift_len   (shift_len),
    .err_clr     (err_clr),
    .chain_in    (chain_in),
    .so          (so),
    .shift_cnt   (shift_cnt),
    .shift_done  (shift_done),
    .short_err   (short_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        se;
    logic        hold;
    logic        cm;
    logic        clr;
    logic [11:0] len;
    logic [3:0]  chain;
    logic [3:0]  exp_so;
    logic [11:0] exp_cnt;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  localparam int unsigned NVEC = 32;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input int s, h, c, cl, l, ch, eso, ecnt, ed, ee);
    vec_t v;
    v.se       = 1'(s);
    v.hold     = 1'(h);
    v.cm       = 1'(c);
    v.clr      = 1'(cl);
    v.len      = 12'(l);
    v.chain    = 4'(ch);
    v.exp_so   = 4'(eso);
    v.exp_cnt  = 12'(ecnt);
    v.exp_done = 1'(ed);
    v.exp_err  = 1'(ee);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int eso, ecnt, ed, ee);
    check({tag, " so"},         32'(so),         32'(eso));
    check({tag, " shift_cnt"},  32'(shift_cnt),  32'(ecnt));
    check({tag, " shift_done"}, 32'(shift_done), 32'(ed));
    check({tag, " short_err"},  32'(short_err),  32'(ee));
  endtask

  task automatic drive(input int s, h, c, l, ch, cl);
    se           = 1'(s);
    hold_outputs = 1'(h);
    compact_mode = 1'(c);
    shift_len    = 12'(l);
    chain_in     = 4'(ch);
    err_clr      = 1'(cl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            se h cm clr len chain     so     cnt done err
    vecs[0]  = mk(1, 0, 0, 0, 5, 'b1010, 'b0000, 1, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 5, 'b0000, 'b1010, 2, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 3, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 4, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 5, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 5, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 5, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 5, 'b0000, 'b0000, 5, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 5, 'b0000, 'b0000, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 1, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 2, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 3, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 5, 'b0000, 'b0000, 3, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 5, 'b0000, 'b0000, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 1, 5, 'b0000, 'b0000, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 5, 'b0000, 'b0000, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 5, 'b0000, 'b0000, 1, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 5, 'b0000, 'b0000, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 1, 5, 'b0000, 'b0000, 0, 0, 0);
    vecs[19] = mk(1, 0, 1, 0, 5, 'b0111, 'b0000, 1, 0, 0);
    vecs[20] = mk(1, 0, 0, 0, 5, 'b0000, 'b0001, 2, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 5, 'b1000, 'b0000, 3, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 5, 'b0000, 'b0001, 4, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 5, 'b0000, 'b0001, 4, 0, 1);
    vecs[24] = mk(0, 0, 0, 0, 5, 'b0000, 'b1000, 0, 0, 1);
    vecs[25] = mk(0, 0, 0, 1, 5, 'b0000, 'b1000, 0, 0, 0);
    vecs[26] = mk(1, 0, 0, 0, 0, 'b0000, 'b0000, 1, 1, 0);
    vecs[27] = mk(1, 0, 0, 0, 0, 'b0000, 'b0000, 1, 0, 0);
    vecs[28] = mk(0, 0, 0, 0, 0, 'b0000, 'b0000, 1, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 0, 'b0000, 'b0000, 0, 0, 0);
    vecs[30] = mk(1, 1, 0, 0, 5, 'b0000, 'b0000, 0, 0, 0);
    vecs[31] = mk(0, 0, 0, 0, 5, 'b0000, 'b0000, 0, 0, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    expect_out("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(int'(vecs[i].se), int'(vecs[i].hold), int'(vecs[i].cm), int'(vecs[i].len),
            int'(vecs[i].chain), int'(vecs[i].clr));
      tick();
      expect_out($sformatf("vec%0d", i), int'(vecs[i].exp_so), int'(vecs[i].exp_cnt),
                 int'(vecs[i].exp_done), int'(vecs[i].exp_err));
    end

    // Hold mid-SHIFT delays completion by the held cycles; shift_len change mid-pattern ignored.
    drive(1, 0, 0, 4, 'b0001, 0); tick(); expect_out("hold_start", 'b0000, 1, 0, 0);
    drive(1, 0, 0, 2, 'b0000, 0); tick(); expect_out("hold_pre",   'b0001, 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 2, 'b1111, 0); tick();
      expect_out($sformatf("hold_frz%0d", k), 'b0001, 2, 0, 0);
    end
    drive(1, 0, 0, 2, 'b0000, 0); tick(); expect_out("hold_resume", 'b0000, 3, 0, 0);
    tick();                               expect_out("hold_done",   'b0000, 4, 1, 0);
    drive(0, 0, 0, 2, 'b0000, 0); tick(); expect_out("hold_exit",   'b0000, 4, 0, 0);
    tick();                               expect_out("hold_idle",   'b0000, 0, 0, 0);

    // se dropped while held still aborts the pattern.
    drive(1, 0, 0, 4, 'b0000, 0); tick(); expect_out("habort_start", 'b0000, 1, 0, 0);
    drive(0, 1, 0, 4, 'b0000, 0); tick(); expect_out("habort_err",   'b0000, 1, 0, 1);
    drive(0, 0, 0, 4, 'b0000, 1); tick(); expect_out("habort_clr",   'b0000, 0, 0, 0);

    // Asynchronous reset mid-SHIFT.
    drive(1, 0, 0, 5, 'b1111, 0);
    tick(); expect_out("rst_s1", 'b0000, 1, 0, 0);
    tick(); expect_out("rst_s2", 'b1111, 2, 0, 0);
    tick(); expect_out("rst_s3", 'b1111, 3, 0, 0);
    #2 rst = 1'b1;
    #1 expect_out("rst_async", 0, 0, 0, 0);
    drive(0, 0, 0, 5, 'b0000, 0);
    tick(); expect_out("rst_held", 0, 0, 0, 0);
    rst = 1'b0;
    tick(); expect_out("rst_idle",    0, 0, 0, 0);
    drive(1, 0, 0, 5, 'b0000, 0);
    tick(); expect_out("rst_restart", 0, 1, 0, 0);
    drive(0, 0, 0, 5, 'b0000, 0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_retime_bank.md
SCAN_RETIME_BANK -- requirements
Module: scan_retime_bank

Interface
REQ-001 Parameter NUM_CHAINS, 4, number of scan-out channels (1..16).
REQ-002 Parameter SKEW_DEPTH, 1, retiming flop stages per channel (1..4).
REQ-003 Parameter CNT_W, 12, width of the shift counter and shift_len.
REQ-004 Port clk  in  1  single clock for all state; all flops rising-edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port se  in  1  scan enable; high = shift cycle.
REQ-007 Port hold_outputs  in  1  freeze so and the counter.
REQ-008 Port compact_mode  in  1  0 = parallel, 1 = XOR-compact.
REQ-009 Port shift_len  in  CNT_W  shift cycles per pattern; 0 treated as 1.
REQ-010 Port err_clr  in  1  clears the sticky short_err flag.
REQ-011 Port chain_in  in  NUM_CHAINS  raw scan-out bits from the core chains.
REQ-012 Port so  out  NUM_CHAINS  retimed scan outputs.
REQ-013 Port shift_cnt  out  CNT_W  shift cycles completed in the current pattern.
REQ-014 Port shift_done  out  1  one-cycle pulse on the last shift of a pattern.
REQ-015 Port short_err  out  1  sticky; se dropped before shift_len shifts completed.

Function
REQ-016 Each channel SHALL pass chain_in[i] through SKEW_DEPTH flops; so SHALL lag chain_in by exactly SKEW_DEPTH cycles while se=1 and hold_outputs=0.
REQ-017 Retiming stages SHALL advance only when se=1 and hold_outputs=0; otherwise every stage SHALL hold its value.
REQ-018 In parallel mode so[i] SHALL equal the last stage of channel i.
REQ-019 In compact mode so[0] SHALL equal the XOR of all last stages, and so[NUM_CHAINS-1:1] SHALL be 0.
REQ-020 compact_mode SHALL be sampled only in IDLE; a change during SHIFT SHALL take effect from the next pattern.
REQ-021 FSM states: IDLE, SHIFT, DONE.
REQ-022 IDLE->SHIFT when se=1 and hold_outputs=0; that cycle counts as shift 1.
REQ-023 In SHIFT, each advancing cycle SHALL increment shift_cnt by 1.
REQ-024 SHIFT->DONE on the cycle shift_cnt reaches max(shift_len,1); shift_done SHALL be high on exactly that cycle.
REQ-025 DONE->IDLE when se=0; while in DONE with se=1, shift_cnt SHALL saturate and shift_done SHALL stay low.
REQ-026 SHIFT->IDLE when se=0 before completion; short_err SHALL be set on that cycle.
REQ-027 IDLE entry SHALL clear shift_cnt to 0 on the following cycle.
REQ-028 hold_outputs=1 in SHIFT SHALL freeze the state, shift_cnt and so; se=0 while held SHALL still cause the SHIFT->IDLE abort.
REQ-029 shift_len SHALL be latched on IDLE->SHIFT; changes mid-pattern SHALL be ignored.
REQ-030 err_clr and a new short_err event in the same cycle: set SHALL win.
REQ-031 The counter SHALL never wrap; at 2^CNT_W-1 it SHALL saturate.

Reset
REQ-032 rst=1 SHALL asynchronously force: FSM=IDLE, all retiming stages 0, so=0, shift_cnt=0, shift_done=0, short_err=0, latched mode=parallel, latched length=1.
REQ-033 Reset asserted mid-SHIFT SHALL abort the pattern without setting short_err.
REQ-034 After deassertion, the first IDLE->SHIFT SHALL occur no earlier than the first rising edge with rst=0.

Structure
REQ-035 The FSM state enum, the mode encoding and the SKEW_DEPTH/NUM_CHAINS legal-range constants SHALL live in the shared scan package.
REQ-036 One sub-module, scan_retime_stage (single channel, SKEW_DEPTH flops with advance enable), SHALL be instantiated NUM_CHAINS times.
REQ-037 Out-of-range parameters SHALL be rejected at elaboration.

Verification
REQ-038 NUM_CHAINS=4, SKEW_DEPTH=2, parallel: chain_in=4'b1010 for one cycle then 0 with se=1 -> so=4'b1010 exactly 2 cycles later, 0 after.
REQ-039 shift_len=5, se high 7 cycles -> shift_done on cycle 5 only, shift_cnt holds at 5, short_err=0; se low -> IDLE, shift_cnt=0.
REQ-040 shift_len=5, se low after 3 shifts -> short_err=1 and stays 1; err_clr -> 0; err_clr coincident with a new abort -> stays 1.
REQ-041 compact_mode=1, chain_in=4'b0111 -> so=4'b0001 after SKEW_DEPTH cycles; toggling compact_mode mid-pattern -> no change until next IDLE.
REQ-042 hold_outputs=1 for 3 cycles mid-SHIFT -> so, shift_cnt frozen; pattern completes 3 cycles later than without hold.
REQ-043 rst pulse mid-SHIFT (shift_cnt=3) -> immediate so=0, shift_cnt=0, IDLE, short_err=0.
